// File: rtl/pipe_fwd_stage_pkg.sv
// Shared definitions for the execute-boundary forwarding stage.
// Holds the x0 register index, default widths and the buffer state encoding.
package pipe_pkg;

  // Register index that is hard-wired to zero and never forwarded.
  localparam int unsigned REG_X0 = 0;

  // Default operand and register-index widths.
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned IDX_W_DEF = 5;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_fwd_stage_if.sv
// Bundle of the upstream, downstream, forwarding and flush signals of pipe_fwd_stage.
// The slave modport is the stage itself; master is the side that drives it.
interface pipe_fwd_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PLD_W   = 128,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned IDX_W   = 5
);

  logic                       flush_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [PLD_W-1:0]           in_pld_i;
  logic [NUM_SRC*IDX_W-1:0]   in_rs_idx_i;
  logic [NUM_SRC*XLEN-1:0]    in_rs_data_i;
  logic [NUM_FWD-1:0]         fwd_wen_i;
  logic [NUM_FWD*IDX_W-1:0]   fwd_idx_i;
  logic [NUM_FWD*XLEN-1:0]    fwd_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [PLD_W-1:0]           out_pld_o;
  logic [NUM_SRC*IDX_W-1:0]   out_rs_idx_o;
  logic [NUM_SRC*XLEN-1:0]    out_rs_data_o;
  logic [NUM_SRC-1:0]         out_fwd_hit_o;

  modport slave (
    input  flush_i,
    input  in_valid_i,
    output in_ready_o,
    input  in_pld_i,
    input  in_rs_idx_i,
    input  in_rs_data_i,
    input  fwd_wen_i,
    input  fwd_idx_i,
    input  fwd_data_i,
    output out_valid_o,
    input  out_ready_i,
    output out_pld_o,
    output out_rs_idx_o,
    output out_rs_data_o,
    output out_fwd_hit_o
  );

  modport master (
    output flush_i,
    output in_valid_i,
    input  in_ready_o,
    output in_pld_i,
    output in_rs_idx_i,
    output in_rs_data_i,
    output fwd_wen_i,
    output fwd_idx_i,
    output fwd_data_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_pld_o,
    input  out_rs_idx_o,
    input  out_rs_data_o,
    input  out_fwd_hit_o
  );

endinterface

// File: rtl/pipe_fwd_stage_fwd_sel.sv
// Priority forward mux for a single operand: the lowest-numbered forwarding
// source whose written rd matches the operand index overrides the stored data.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic [XLEN-1:0]          data,
  input  logic [NUM_FWD-1:0]       fwd_wen,
  input  logic [NUM_FWD*IDX_W-1:0] fwd_idx,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]          res,
  output logic                     hit
);

  logic not_x0;

  assign not_x0 = (idx != IDX_W'(REG_X0));

  // Walk from lowest to highest priority so the youngest matching producer wins.
  always_comb begin
    res = data;
    hit = 1'b0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_wen[j] && not_x0 && (idx == fwd_idx[j*IDX_W +: IDX_W])) begin
        res = fwd_data[j*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_fwd_stage.sv
// Execute-boundary pipeline register with a two-entry skid buffer (MAIN/SKID),
// registered in_ready_o, priority operand forwarding and synchronous flush.
// Held operands are re-resolved every stalled cycle so a producer that retires
// during a stall is captured.
// Build option: PIPE_FWD_STAGE_OUT_MASK_EN zeroes payload, indices and operand
// data outputs while the stage is empty.
module pipe_fwd_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned PLD_W   = 128,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_fwd_stage_if.slave  bus
);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;

  logic [PLD_W-1:0]                 main_pld_q, main_pld_d;
  logic [NUM_SRC-1:0][IDX_W-1:0]    main_idx_q, main_idx_d;
  logic [NUM_SRC-1:0][XLEN-1:0]     main_data_q, main_data_d;
  logic [PLD_W-1:0]                 skid_pld_q, skid_pld_d;
  logic [NUM_SRC-1:0][IDX_W-1:0]    skid_idx_q, skid_idx_d;
  logic [NUM_SRC-1:0][XLEN-1:0]     skid_data_q, skid_data_d;

  logic [NUM_SRC-1:0][IDX_W-1:0]    in_idx;
  logic [NUM_SRC-1:0][XLEN-1:0]     in_data;

  logic [NUM_SRC-1:0][XLEN-1:0]     main_res, skid_res, in_res;
  logic [NUM_SRC-1:0]               main_hit, skid_hit, in_hit;

  logic out_valid;
  logic accept;
  logic pop;

  assign in_idx  = bus.in_rs_idx_i;
  assign in_data = bus.in_rs_data_i;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid_i & in_ready_q;
  assign pop       = out_valid & bus.out_ready_i;

  // One resolver per operand for each of MAIN, SKID and the incoming beat.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_sel
    fwd_sel #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD),
      .IDX_W   (IDX_W)
    ) u_main_sel (
      .idx      (main_idx_q[k]),
      .data     (main_data_q[k]),
      .fwd_wen  (bus.fwd_wen_i),
      .fwd_idx  (bus.fwd_idx_i),
      .fwd_data (bus.fwd_data_i),
      .res      (main_res[k]),
      .hit      (main_hit[k])
    );

    fwd_sel #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD),
      .IDX_W   (IDX_W)
    ) u_skid_sel (
      .idx      (skid_idx_q[k]),
      .data     (skid_data_q[k]),
      .fwd_wen  (bus.fwd_wen_i),
      .fwd_idx  (bus.fwd_idx_i),
      .fwd_data (bus.fwd_data_i),
      .res      (skid_res[k]),
      .hit      (skid_hit[k])
    );

    fwd_sel #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD),
      .IDX_W   (IDX_W)
    ) u_in_sel (
      .idx      (in_idx[k]),
      .data     (in_data[k]),
      .fwd_wen  (bus.fwd_wen_i),
      .fwd_idx  (bus.fwd_idx_i),
      .fwd_data (bus.fwd_data_i),
      .res      (in_res[k]),
      .hit      (in_hit[k])
    );
  end

  // Only MAIN's hit vector is visible; the others exist for the resolved data.
  logic unused_hit;
  assign unused_hit = ^{skid_hit, in_hit};

  // Next-state, entry loads and stall refresh; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_pld_d  = main_pld_q;
    main_idx_d  = main_idx_q;
    main_data_d = main_data_q;
    skid_pld_d  = skid_pld_q;
    skid_idx_d  = skid_idx_q;
    skid_data_d = skid_data_q;

    if (bus.flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_pld_d  = bus.in_pld_i;
            main_idx_d  = in_idx;
            main_data_d = in_res;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_pld_d  = bus.in_pld_i;
            main_idx_d  = in_idx;
            main_data_d = in_res;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_pld_d  = bus.in_pld_i;
            skid_idx_d  = in_idx;
            skid_data_d = in_res;
            main_data_d = main_res;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else begin
            main_data_d = main_res;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so no accept can coincide.
          if (pop) begin
            state_d     = ST_ONE;
            main_pld_d  = skid_pld_q;
            main_idx_d  = skid_idx_q;
            main_data_d = skid_res;
          end else begin
            main_data_d = main_res;
            skid_data_d = skid_res;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready flop and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_pld_q  <= '0;
      main_idx_q  <= '0;
      main_data_q <= '0;
      skid_pld_q  <= '0;
      skid_idx_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_pld_q  <= main_pld_d;
      main_idx_q  <= main_idx_d;
      main_data_q <= main_data_d;
      skid_pld_q  <= skid_pld_d;
      skid_idx_q  <= skid_idx_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign bus.in_ready_o    = in_ready_q;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_fwd_hit_o = main_hit & {NUM_SRC{out_valid}};

`ifdef PIPE_FWD_STAGE_OUT_MASK_EN
  assign bus.out_pld_o     = main_pld_q & {PLD_W{out_valid}};
  assign bus.out_rs_idx_o  = main_idx_q & {(NUM_SRC*IDX_W){out_valid}};
  assign bus.out_rs_data_o = main_res & {(NUM_SRC*XLEN){out_valid}};
`else
  assign bus.out_pld_o     = main_pld_q;
  assign bus.out_rs_idx_o  = main_idx_q;
  assign bus.out_rs_data_o = main_res;
`endif

endmodule
